// File: rtl/pcm_sample_pacer.sv
// PCM sample pacer: buffers producer samples in a FIFO and releases one
// per audio tick through a saturating Q1.4 gain stage to the DAC feed.
module pcm_sample_pacer #(
  parameter int PCM_BITS   = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 521
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PCM_BITS-1:0]           in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4:0]                    gain,
  output logic [PCM_BITS-1:0]           pcm,
  output logic                          pcm_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          underrun,
  input  logic                          underrun_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int PW = PCM_BITS + 6;

  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  localparam logic [PCM_BITS-1:0] MAXV =
    {1'b0, {(PCM_BITS-1){1'b1}}};
  localparam logic [PCM_BITS-1:0] MINV =
    {1'b1, {(PCM_BITS-1){1'b0}}};

  logic [PCM_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       cnt;
  logic                en;
  logic                tick;
  logic                empty;
  logic                push;
  logic                pop;

  logic                       s1_v;
  logic signed [PCM_BITS-1:0] s1_sample;
  logic [4:0]                 s1_gain;

  logic signed [PW-1:0] s1_ext;
  logic signed [PW-1:0] g_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] res;
  logic [PW-PCM_BITS:0] upper;
  logic                 over;
  logic                 under;
  logic [PCM_BITS-1:0]  sat;

  assign tick     = cnt == LAST;
  assign empty    = fill == '0;
  assign in_ready = en && (fill != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = tick && !empty;

  // en holds in_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= 1'b0;
      cnt <= '0;
    end else begin
      en  <= 1'b1;
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // An empty tick feeds silence rather than repeating the last sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_sample <= '0;
      s1_gain   <= '0;
    end else begin
      s1_v <= tick;
      if (tick) begin
        s1_sample <= empty ? '0 : mem[rd_ptr];
        s1_gain   <= gain;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (tick && empty) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  assign s1_ext = PW'(s1_sample);
  assign g_ext  = PW'($signed({1'b0, s1_gain}));
  assign prod   = s1_ext * g_ext;
  assign res    = prod >>> 4;
  assign upper  = res[PW-1:PCM_BITS-1];
  assign over   = !res[PW-1] && (|upper);
  assign under  = res[PW-1] && !(&upper);

  always_comb begin
    sat = res[PCM_BITS-1:0];
    unique case (1'b1)
      over:    sat = MAXV;
      under:   sat = MINV;
      default: sat = res[PCM_BITS-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm        <= '0;
      pcm_strobe <= 1'b0;
    end else begin
      pcm_strobe <= s1_v;
      if (s1_v) pcm <= sat;
    end
  end

endmodule

// File: tb/tb_pcm_sample_pacer.sv
// Bench for pcm_sample_pacer: queue-based reference model, directed
// scenarios and randomized producer traffic.
module tb_pcm_sample_pacer;

  localparam int PB    = 12;
  localparam int DEPTH = 16;
  localparam int CD    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PB-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    gain = 5'd16;
  logic [PB-1:0] pcm;
  logic          pcm_strobe;
  logic [4:0]    fill;
  logic          underrun;
  logic          underrun_clr = 1'b0;

  always #5 clk = ~clk;

  pcm_sample_pacer #(
    .PCM_BITS(PB), .FIFO_DEPTH(DEPTH), .CLK_DIV(CD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .gain(gain),
    .pcm(pcm), .pcm_strobe(pcm_strobe),
    .fill(fill), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // floor(x*g/16) clamped to the signed PCM range
  function automatic int scale(input int x, input int g);
    int p;
    int r;
    p = x * g;
    if (p >= 0) r = p / 16;
    else        r = -((-p + 15) / 16);
    if (r > 2047)  r = 2047;
    if (r < -2048) r = -2048;
    return r;
  endfunction

  int mq[$];
  int m_cnt = 0;
  bit m_en = 0, m_acc = 0, m_stb = 0, m_und = 0, nx_v = 0;
  int m_pcm = 0, nx_val = 0;
  bit tk, emp;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0; m_en = 0; m_acc = 0; m_stb = 0;
      m_und = 0; nx_v = 0; m_pcm = 0; nx_val = 0;
    end else begin
      tk    = (m_cnt % CD) == CD - 1;
      emp   = mq.size() == 0;
      m_acc = in_valid && m_en && mq.size() < DEPTH;
      m_stb = nx_v;
      if (nx_v) m_pcm = nx_val;
      nx_v = tk;
      if (tk) begin
        if (emp) nx_val = 0;
        else     nx_val = scale(mq.pop_front(), int'(gain));
      end
      if (tk && emp)         m_und = 1;
      else if (underrun_clr) m_und = 0;
      if (m_acc) mq.push_back(int'($signed(in_data)));
      m_cnt++;
      m_en = 1;
    end
  end

  int cyc = -1;
  int sv[$];
  int st[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = -1;
      sv.delete();
      st.delete();
    end else begin
      cyc++;
      if (pcm_strobe) begin
        sv.push_back(int'($signed(pcm)));
        st.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_fill", int'(fill), 0);
      chk("rst_pcm", int'(pcm), 0);
      chk("rst_strobe", int'(pcm_strobe), 0);
      chk("rst_underrun", int'(underrun), 0);
    end else begin
      chk("ready", int'(in_ready),
          int'(m_en && mq.size() < DEPTH));
      chk("fill", int'(fill), mq.size());
      chk("pcm", int'($signed(pcm)), m_pcm);
      chk("strobe", int'(pcm_strobe), int'(m_stb));
      chk("underrun", int'(underrun), int'(m_und));
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    underrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input int x);
    in_valid = 1'b1;
    in_data  = PB'(x);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_acc) break;
    end
    if (!m_acc) chk("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sv.size() >= n) break;
    end
    @(negedge clk);
    if (sv.size() < n) chk("strobe_timeout", sv.size(), n);
  endtask

  function automatic int val(input int k);
    return (k * 53 + 7) % 2048;
  endfunction

  int tx[6] = '{2047, -2048, 1024, -3, 1445, 291};
  int tg[6] = '{31, 31, 8, 8, 0, 16};
  int te[6] = '{2047, -2048, 512, -2, 0, 291};
  int pacing[4] = '{256, 512, 768, 0};
  int pushed[$];
  int k;
  int vp;

  initial begin
    do_reset();
    chk("ready_pre", int'(in_ready), 0);
    @(negedge clk);
    chk("ready_post", int'(in_ready), 1);
    chk("idle_pcm", int'(pcm), 0);
    wait_strobes(1);
    if (st.size() > 0) begin
      chk("first_strobe_cyc", st[0], CD + 1);
      chk("first_pcm", sv[0], 0);
    end
    chk("idle_underrun", int'(underrun), 1);

    do_reset();
    gain = 5'd16;
    push(256);
    push(512);
    push(768);
    wait_strobes(4);
    if (sv.size() >= 4) begin
      chk("pace_t0", st[0], CD + 1);
      for (int i = 0; i < 4; i++) begin
        chk("pace_val", sv[i], pacing[i]);
        if (i > 0) chk("pace_gap", st[i] - st[i-1], CD);
      end
    end
    chk("pace_underrun", int'(underrun), 1);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      gain = 5'(tg[i]);
      push(tx[i]);
      wait_strobes(i + 1);
      if (sv.size() > i) chk("gain_sat", sv[i], te[i]);
    end
    gain = 5'd3;
    repeat (3) @(negedge clk);
    chk("gain_hold", int'($signed(pcm)), 291);

    do_reset();
    gain = 5'd16;
    pushed.delete();
    k = 0;
    in_valid = 1'b1;
    in_data = PB'(val(k));
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_acc) begin
        pushed.push_back(val(k));
        k++;
        in_data = PB'(val(k));
      end
      if (mq.size() == DEPTH) break;
    end
    chk("full_fill", int'(fill), DEPTH);
    chk("full_ready", int'(in_ready), 0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_acc) break;
    end
    chk("held_accept", int'(m_acc), 1);
    chk("held_fill", int'(fill), DEPTH);
    pushed.push_back(val(k));
    in_valid = 1'b0;
    wait_strobes(pushed.size());
    for (int i = 0; i < pushed.size(); i++)
      if (i < sv.size()) chk("order", sv[i], pushed[i]);

    do_reset();
    repeat (7) @(negedge clk);
    in_valid = 1'b1;
    in_data = PB'(12'h155);
    @(negedge clk);
    in_valid = 1'b0;
    chk("tick_push_und", int'(underrun), 1);
    chk("tick_push_fill", int'(fill), 1);
    repeat (7) @(negedge clk);
    in_valid = 1'b1;
    in_data = PB'(12'h0AA);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pushpop_fill", int'(fill), 1);
    wait_strobes(3);
    if (sv.size() >= 3) begin
      chk("pp_v0", sv[0], 0);
      chk("pp_v1", sv[1], 12'h155);
      chk("pp_v2", sv[2], 12'h0AA);
    end

    do_reset();
    repeat (7) @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("clr_loses", int'(underrun), 1);
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("clr_wins", int'(underrun), 0);

    for (int s = 0; s < 3; s++) begin
      vp = (s == 0) ? 15 : (s == 1) ? 55 : 95;
      do_reset();
      for (int c = 0; c < 1000; c++) begin
        if (c == 500) do_reset();
        @(negedge clk);
        if (!in_valid || m_acc) begin
          in_valid = ($urandom_range(99) < vp);
          in_data  = PB'($urandom);
        end
        if ($urandom_range(19) == 0)
          gain = 5'($urandom_range(31));
        underrun_clr = ($urandom_range(15) == 0);
      end
      in_valid = 1'b0;
      underrun_clr = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
